// File: rtl/count_monitor.sv
// Sequence checker for an up-counter stream: acquires lock after a run of
// correct increments, then flags wraps and out-of-sequence samples.
module count_monitor #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned LOCK_COUNT = 2,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [WIDTH-1:0] count,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected,
    output logic [1:0]       state
);

    localparam int unsigned RUN_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t             cur_state, nxt_state;
    logic [WIDTH-1:0]   prev, nxt_prev;
    logic [RUN_W-1:0]   run, nxt_run;
    logic [ERR_W-1:0]   nxt_err_count;
    logic               nxt_err, nxt_wrap;
    logic [WIDTH-1:0]   prev_inc, nxt_expected;
    logic [RUN_W-1:0]   run_inc;

    assign prev_inc = WIDTH'(prev + 1'b1);
    assign run_inc  = RUN_W'(run + 1'b1);
    assign state    = cur_state;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= IDLE;
            prev      <= '0;
            run       <= '0;
            err_count <= '0;
            err       <= 1'b0;
            wrap      <= 1'b0;
            locked    <= 1'b0;
            expected  <= '0;
        end else begin
            cur_state <= nxt_state;
            prev      <= nxt_prev;
            run       <= nxt_run;
            err_count <= nxt_err_count;
            err       <= nxt_err;
            wrap      <= nxt_wrap;
            locked    <= (nxt_state == LOCKED);
            expected  <= nxt_expected;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        nxt_state     = cur_state;
        nxt_prev      = prev;
        nxt_run       = run;
        nxt_err_count = err_count;
        nxt_err       = 1'b0;
        nxt_wrap      = 1'b0;

        if (valid) begin
            case (cur_state)
                IDLE: begin
                    nxt_prev  = count;
                    nxt_run   = '0;
                    nxt_state = ACQUIRE;
                end
                ACQUIRE: begin
                    nxt_prev = count;
                    if (count == prev_inc) begin
                        nxt_run = run_inc;
                        if (run_inc == RUN_W'(LOCK_COUNT)) begin
                            nxt_state = LOCKED;
                        end
                    end else begin
                        nxt_run = '0;
                    end
                end
                LOCKED: begin
                    nxt_prev = count;
                    if (count == prev_inc) begin
                        nxt_wrap = (prev == '1) && (count == '0);
                    end else begin
                        nxt_err   = 1'b1;
                        nxt_run   = '0;
                        nxt_state = ACQUIRE;
                        if (err_count != '1) begin
                            nxt_err_count = ERR_W'(err_count + 1'b1);
                        end
                    end
                end
                default: begin
                    nxt_state = IDLE;
                end
            endcase
        end else if (cur_state != IDLE && cur_state != ACQUIRE && cur_state != LOCKED) begin
            // Illegal encoding recovers even without a valid sample
            nxt_state = IDLE;
        end

        nxt_expected = (nxt_state == IDLE) ? '0 : WIDTH'(nxt_prev + 1'b1);
    end

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: vector table plus hand-written
// sequences for valid gaps and error-tally saturation.
module tb_count_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid;
    logic [3:0] count;

    logic       locked, err, wrap;
    logic [7:0] err_count;
    logic [3:0] expected;
    logic [1:0] state;

    logic       s_locked, s_err, s_wrap;
    logic [1:0] s_err_count;
    logic [3:0] s_expected;
    logic [1:0] s_state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    count_monitor #(.WIDTH(4), .LOCK_COUNT(2), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .valid(valid), .count(count),
        .locked(locked), .err(err), .wrap(wrap),
        .err_count(err_count), .expected(expected), .state(state)
    );

    count_monitor #(.WIDTH(4), .LOCK_COUNT(2), .ERR_W(2)) dut_sat (
        .clk(clk), .reset(reset), .valid(valid), .count(count),
        .locked(s_locked), .err(s_err), .wrap(s_wrap),
        .err_count(s_err_count), .expected(s_expected), .state(s_state)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic [3:0] cnt;
        logic [1:0] st;
        logic       lk;
        logic       er;
        logic       wr;
        logic [7:0] ec;
        logic [3:0] ex;
    } vec_t;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %0d, want %0d", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [3:0] c);
        @(negedge clk);
        reset = r;
        valid = v;
        count = c;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic v, logic [3:0] c, logic [1:0] st,
                                logic lk, logic er, logic wr, logic [7:0] ec, logic [3:0] ex);
        vec_t t;
        t.rst = r; t.vld = v; t.cnt = c; t.st = st; t.lk = lk;
        t.er = er; t.wr = wr; t.ec = ec; t.ex = ex;
        return t;
    endfunction

    initial begin
        reset = 1'b1;
        valid = 1'b0;
        count = '0;

        //          rst v  cnt  st lk er wr ec ex
        vecs.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0,  1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1,  1, 0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 1, 2,  2, 1, 0, 0, 0, 3));
        vecs.push_back(mk(0, 1, 3,  2, 1, 0, 0, 0, 4));
        vecs.push_back(mk(0, 1, 4,  2, 1, 0, 0, 0, 5));
        vecs.push_back(mk(0, 1, 5,  2, 1, 0, 0, 0, 6));
        vecs.push_back(mk(0, 1, 9,  1, 0, 1, 0, 1, 10));
        vecs.push_back(mk(0, 1, 10, 1, 0, 0, 0, 1, 11));
        vecs.push_back(mk(0, 1, 11, 2, 1, 0, 0, 1, 12));
        vecs.push_back(mk(0, 1, 12, 2, 1, 0, 0, 1, 13));
        vecs.push_back(mk(0, 1, 13, 2, 1, 0, 0, 1, 14));
        vecs.push_back(mk(0, 1, 14, 2, 1, 0, 0, 1, 15));
        vecs.push_back(mk(0, 1, 15, 2, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0,  2, 1, 0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 1,  2, 1, 0, 0, 1, 2));
        vecs.push_back(mk(0, 1, 1,  1, 0, 1, 0, 2, 2));
        vecs.push_back(mk(0, 1, 2,  1, 0, 0, 0, 2, 3));
        vecs.push_back(mk(0, 1, 3,  2, 1, 0, 0, 2, 4));
        vecs.push_back(mk(1, 1, 4,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 7,  1, 0, 0, 0, 0, 8));
        vecs.push_back(mk(0, 1, 3,  1, 0, 0, 0, 0, 4));
        vecs.push_back(mk(0, 1, 4,  1, 0, 0, 0, 0, 5));
        vecs.push_back(mk(0, 1, 5,  2, 1, 0, 0, 0, 6));
        vecs.push_back(mk(0, 0, 9,  2, 1, 0, 0, 0, 6));
        vecs.push_back(mk(0, 1, 6,  2, 1, 0, 0, 0, 7));
        vecs.push_back(mk(0, 1, 7,  2, 1, 0, 0, 0, 8));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].vld, vecs[i].cnt);
            chk("state",     i, int'(state),     int'(vecs[i].st));
            chk("locked",    i, int'(locked),    int'(vecs[i].lk));
            chk("err",       i, int'(err),       int'(vecs[i].er));
            chk("wrap",      i, int'(wrap),      int'(vecs[i].wr));
            chk("err_count", i, int'(err_count), int'(vecs[i].ec));
            chk("expected",  i, int'(expected),  int'(vecs[i].ex));
        end

        // Locked at 7: five idle cycles with a noisy count, then 8
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 4'($urandom_range(0, 15)));
            chk("gap_locked", i, int'(locked), 1);
            chk("gap_err",    i, int'(err),    0);
            chk("gap_wrap",   i, int'(wrap),   0);
            chk("gap_exp",    i, int'(expected), 8);
        end
        step(1'b0, 1'b1, 4'd8);
        chk("gap_resume_locked", 0, int'(locked),   1);
        chk("gap_resume_err",    0, int'(err),      0);
        chk("gap_resume_exp",    0, int'(expected), 9);

        // Saturating 2-bit tally: 4 errors, each followed by a 2-sample relock
        begin
            logic [3:0] nxt;
            int want_ec;
            nxt = 4'd9;
            for (int k = 0; k < 4; k++) begin
                nxt = 4'(nxt + 4'd5);
                step(1'b0, 1'b1, nxt);
                want_ec = (k + 1 > 3) ? 3 : k + 1;
                chk("sat_err",    k, int'(s_err),       1);
                chk("sat_ec",     k, int'(s_err_count), want_ec);
                chk("sat_locked", k, int'(s_locked),    0);
                nxt = 4'(nxt + 4'd1);
                step(1'b0, 1'b1, nxt);
                chk("sat_err_clr", k, int'(s_err),    0);
                chk("sat_acq",     k, int'(s_state),  1);
                nxt = 4'(nxt + 4'd1);
                step(1'b0, 1'b1, nxt);
                chk("sat_relock",  k, int'(s_locked), 1);
            end
            chk("wide_ec", 0, int'(err_count), 4);
        end

        // Reset while valid and holding errors
        step(1'b1, 1'b1, 4'd3);
        chk("rst_state",  0, int'(state),     0);
        chk("rst_locked", 0, int'(locked),    0);
        chk("rst_ec",     0, int'(err_count), 0);
        chk("rst_exp",    0, int'(expected),  0);
        chk("rst_err",    0, int'(err),       0);
        chk("rst_sat_ec", 0, int'(s_err_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/count_monitor.md
# count_monitor

Sequence checker sitting on the output of the 4-bit up counter. It samples a count stream, acquires lock after a run of correct increments, then flags every wrap (all-ones to zero) and every out-of-sequence value. It also keeps a saturating error tally. It is the receiving end of the counter interface and is used both in-system (health flag) and by benches as a self-checking monitor.

## Interface
Parameters:
- WIDTH, 4, width of the monitored count.
- LOCK_COUNT, 2, consecutive correct increments needed to lock (1..15).
- ERR_W, 8, width of the error tally.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- valid  input  1  count is sampled on edges where valid=1.
- count  input  WIDTH  counter value under test.
- locked  output  1  high while in LOCKED.
- err  output  1  one-cycle pulse on an out-of-sequence sample while LOCKED.
- wrap  output  1  one-cycle pulse on a correct all-ones to zero transition while LOCKED.
- err_count  output  ERR_W  number of err pulses since reset; saturates at all-ones.
- expected  output  WIDTH  value the next sample must equal: (prev+1) mod 2^WIDTH. It is 0 in IDLE.
- state  output  2  IDLE=0, ACQUIRE=1, LOCKED=2 (3 unused; decodes to IDLE).

## Operation
- Internal regs: prev (WIDTH), run (4 bits), plus state.
- Reset: state=IDLE, prev=0, run=0. Outputs: locked=0, err=0, wrap=0, err_count=0, expected=0.
- valid=0: nothing changes. err and wrap are 0, and state, prev, run and err_count all hold.
- IDLE: on valid, prev<=count, run<=0, go to ACQUIRE. No err or wrap is produced.
- ACQUIRE, on valid:
  - If count==expected: prev<=count and run<=run+1. If run+1==LOCK_COUNT, go to LOCKED.
  - Else: prev<=count, run<=0, stay in ACQUIRE.
  - err and wrap are never asserted in ACQUIRE.
- LOCKED, on valid:
  - count==expected: prev<=count. If prev is all-ones and count is 0, pulse wrap.
  - count!=expected: pulse err, err_count<=err_count+1 (saturating), prev<=count, run<=0, go to ACQUIRE.
- Arithmetic: expected wraps modulo 2^WIDTH, so 15 to 0 is a correct increment at WIDTH=4. A repeated value (count==prev) is an error.
- Any reachable illegal state encoding recovers to IDLE on the next edge.

## Timing
- All outputs are registered and update on the same edge that samples count.
- err and wrap are high for exactly the one cycle after the sampling edge, then return to 0. This holds even if valid stays high with another error: a second error gives a second pulse in the next cycle.
- locked rises on the edge that accepts the LOCK_COUNT-th correct increment. From IDLE, the earliest lock is at sample LOCK_COUNT+1: the first sample only seeds prev.
- locked falls on the same edge that raises err. err_count increments on that edge too.
- Reset has priority over valid. Reset mid-stream returns to IDLE on that edge and clears err_count, with no err or wrap pulse. The first valid sample after reset release re-seeds prev.
- At saturation, err_count holds at all-ones. err still pulses.
- Simultaneous wrap and err cannot occur: a sample is either correct or not.

## Test plan
- Reset then valid=1 with counts 0,1,2,3 (LOCK_COUNT=2):
  - state goes IDLE→ACQUIRE→ACQUIRE→LOCKED.
  - locked rises after sample 2 (the 3rd sample) and stays high at sample 3.
  - err_count=0.
- Locked stream ...,14,15,0,1: single wrap pulse the cycle after 0 is sampled. No err, locked stays 1, expected=2 after sample 1.
- Locked at count 5, then drive 9:
  - err pulses one cycle, err_count=1, locked=0, state=ACQUIRE, expected=10.
  - Then 10,11 relocks, with locked rising after sample 11.
- Locked at count 7, hold valid=0 for 5 cycles with count toggling randomly, then valid=1 with count 8: no pulses, locked stays 1 throughout.
- ERR_W=2, locked, then force 4 out-of-sequence samples each followed by 2 correct increments to relock:
  - err pulses 4 times.
  - err_count reads 1,2,3,3.
- Locked with err_count=2, assert reset for one cycle while valid=1:
  - next cycle state=IDLE, locked=0, err_count=0, expected=0.
  - No err pulse.
